// File: rtl/rx_frame_sampler.sv
// Oversampling UART receive front end: synchroniser, start qualification, data/parity/stop sampling.
// Optional RX_MAJORITY_VOTE_EN: 2-of-3 vote over the last three sample-clock cycles of each bit.
module rx_frame_sampler #(
   parameter int unsigned SAMPLE_RATIO = 16,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_MODE  = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 sample_clk,
   input  logic                 rst_n,
   input  logic                 din,
   output logic                 sample_sig,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);
   localparam int unsigned      CNT_W         = $clog2(SAMPLE_RATIO);
   localparam int unsigned      HALF          = SAMPLE_RATIO / 2;
   localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(SAMPLE_RATIO - 1);
   localparam logic [CNT_W-1:0] CNT_START_CHK = CNT_W'(HALF - 1);
   localparam logic [3:0]       DATA_LAST     = 4'(DATA_BITS - 1);
   localparam logic [3:0]       STOP_LAST     = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [3:0]           bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_pend_q, par_pend_d;
   logic                 frm_pend_q, frm_pend_d;
   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic                 data_valid_q, data_valid_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 busy_q;
   logic                 sync1_q, ds_q;
   logic                 bit_tick;
   logic                 bit_val;

   // Two-flop synchroniser; idles high so reset never looks like a start bit
   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         ds_q    <= 1'b1;
      end else begin
         sync1_q <= din;
         ds_q    <= sync1_q;
      end
   end

   assign bit_tick = (count_q == CNT_LAST);

`ifdef RX_MAJORITY_VOTE_EN
   localparam logic [CNT_W-1:0] CNT_VOTE0 = CNT_W'(SAMPLE_RATIO - 3);
   localparam logic [CNT_W-1:0] CNT_VOTE1 = CNT_W'(SAMPLE_RATIO - 2);
   logic vote0_q, vote1_q;

   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) begin
         vote0_q <= 1'b1;
         vote1_q <= 1'b1;
      end else begin
         if (count_q == CNT_VOTE0) vote0_q <= ds_q;
         if (count_q == CNT_VOTE1) vote1_q <= ds_q;
      end
   end

   assign bit_val = (vote0_q & vote1_q) | (vote0_q & ds_q) | (vote1_q & ds_q);
`else
   assign bit_val = ds_q;
`endif

   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         count_q      <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         par_pend_q   <= 1'b0;
         frm_pend_q   <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         par_pend_q   <= par_pend_d;
         frm_pend_q   <= frm_pend_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         busy_q       <= (state_d != S_IDLE);
      end
   end

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      par_pend_d   = par_pend_q;
      frm_pend_d   = frm_pend_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;

      if (state_q != S_IDLE) begin
         count_d = bit_tick ? '0 : count_q + CNT_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            count_d = '0;
            if (!ds_q) state_d = S_START;
         end
         S_START: begin
            if (count_q == CNT_START_CHK) begin
               count_d = '0;
               if (ds_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d    = S_DATA;
                  bit_idx_d  = '0;
                  par_pend_d = 1'b0;
                  frm_pend_d = 1'b0;
               end
            end
         end
         S_DATA: begin
            // Right shift: after DATA_BITS samples the first (LSB) bit sits at index 0
            if (bit_tick) begin
               shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
               if (bit_idx_q == DATA_LAST) begin
                  bit_idx_d = '0;
                  state_d   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_tick) begin
               par_pend_d = (^shift_q) ^ bit_val ^ (PARITY_MODE == 2);
               state_d    = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_tick) begin
               frm_pend_d = frm_pend_q | ~bit_val;
               if (bit_idx_q == STOP_LAST) begin
                  state_d      = S_IDLE;
                  bit_idx_d    = '0;
                  data_out_d   = shift_q;
                  parity_err_d = par_pend_q;
                  frame_err_d  = frm_pend_d;
                  data_valid_d = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign sample_sig = (state_q == S_DATA) && bit_tick;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_rx_frame_sampler.sv
// Directed bench for rx_frame_sampler: default instance plus an even-parity instance on a separate line.
module tb_rx_frame_sampler;
   localparam int SR   = 16;
   localparam int HALF = SR / 2;

`ifdef RX_MAJORITY_VOTE_EN
   localparam logic [7:0] GLITCH_EXP = 8'hA5;
`else
   localparam logic [7:0] GLITCH_EXP = 8'hA4;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       din, din_p;
   logic       sample_sig, data_valid, parity_err, frame_err, busy;
   logic [7:0] data_out;
   logic       sample_sig_p, data_valid_p, parity_err_p, frame_err_p, busy_p;
   logic [7:0] data_out_p;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int valid_cyc = 0;
   int consec = 0;
   int e0;
   logic prev_valid = 1'b0;
   logic [9:0] vq[$];
   logic [9:0] vpq[$];
   int ssq[$];

   always #5 clk = ~clk;

   rx_frame_sampler u_dut (
      .sample_clk (clk),
      .rst_n      (rst_n),
      .din        (din),
      .sample_sig (sample_sig),
      .data_out   (data_out),
      .data_valid (data_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   rx_frame_sampler #(.PARITY_MODE(1)) u_dut_par (
      .sample_clk (clk),
      .rst_n      (rst_n),
      .din        (din_p),
      .sample_sig (sample_sig_p),
      .data_out   (data_out_p),
      .data_valid (data_valid_p),
      .parity_err (parity_err_p),
      .frame_err  (frame_err_p),
      .busy       (busy_p)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Capture completions and sample strobes away from the active edge
   always @(negedge clk) begin
      if (data_valid) begin
         vq.push_back({frame_err, parity_err, data_out});
         valid_cyc = cyc;
         if (prev_valid) consec++;
      end
      prev_valid = data_valid;
      if (sample_sig) ssq.push_back(cyc);
      if (data_valid_p) vpq.push_back({frame_err_p, parity_err_p, data_out_p});
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_line(input int sel, input logic v);
      if (sel == 0) din = v;
      else din_p = v;
   endtask

   task automatic send_level(input int sel, input logic v, input int n);
      set_line(sel, v);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input int sel, input logic [7:0] data, input bit has_par,
                             input logic par_bit, input logic stop_val, input int glitch_bit);
      send_level(sel, 1'b0, SR);
      for (int i = 0; i < 8; i++) begin
         if (i == glitch_bit) begin
            send_level(sel, data[i], HALF);
            send_level(sel, 1'b0, 1);
            send_level(sel, data[i], SR - HALF - 1);
         end else begin
            send_level(sel, data[i], SR);
         end
      end
      if (has_par) send_level(sel, par_bit, SR);
      send_level(sel, stop_val, SR);
      set_line(sel, 1'b1);
   endtask

   task automatic expect_frame(input int sel, input string tag, input logic [7:0] d,
                               input logic pe, input logic fe);
      logic [9:0] e;
      int n;
      n = (sel == 0) ? vq.size() : vpq.size();
      check_eq({tag, "_cnt"}, 32'(n), 32'd1);
      if (n > 0) begin
         if (sel == 0) e = vq.pop_front();
         else e = vpq.pop_front();
         check_eq({tag, "_data"}, 32'(e[7:0]), 32'(d));
         check_eq({tag, "_perr"}, 32'(e[8]), 32'(pe));
         check_eq({tag, "_ferr"}, 32'(e[9]), 32'(fe));
      end
      vq.delete();
      vpq.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      din   = 1'b1;
      din_p = 1'b1;
      idle(3);
      check_eq("rst_data",  32'(data_out),   32'd0);
      check_eq("rst_valid", 32'(data_valid), 32'd0);
      check_eq("rst_perr",  32'(parity_err), 32'd0);
      check_eq("rst_ferr",  32'(frame_err),  32'd0);
      check_eq("rst_busy",  32'(busy),       32'd0);
      check_eq("rst_ss",    32'(sample_sig), 32'd0);
      rst_n = 1'b1;
      idle(5);

      // Basic frame: value, latency and sample strobe spacing
      vq.delete();
      ssq.delete();
      e0 = cyc;
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
      idle(4);
      check_eq("a5_lat", 32'(valid_cyc - e0), 32'(2 + 1 + HALF + 9 * SR));
      expect_frame(0, "a5", 8'hA5, 1'b0, 1'b0);
      check_eq("a5_ss_n", 32'(ssq.size()), 32'd8);
      if (ssq.size() == 8) begin
         check_eq("a5_ss_first", 32'(ssq[0] - e0), 32'(2 + HALF + SR));
         for (int i = 1; i < 8; i++) check_eq("a5_ss_gap", 32'(ssq[i] - ssq[i-1]), 32'(SR));
      end
      check_eq("a5_busy_end", 32'(busy), 32'd0);
      check_eq("a5_hold", 32'(data_out), 32'hA5);

      // False start: 4-cycle low pulse
      send_level(0, 1'b0, 4);
      check_eq("fs_busy_hi", 32'(busy), 32'd1);
      send_level(0, 1'b1, 20);
      check_eq("fs_busy_lo", 32'(busy), 32'd0);
      check_eq("fs_no_valid", 32'(vq.size()), 32'd0);
      check_eq("fs_hold", 32'(data_out), 32'hA5);

      // Stop bit low, then a clean frame clears the flag
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, -1);
      idle(40);
      expect_frame(0, "ferr", 8'h3C, 1'b0, 1'b1);
      check_eq("ferr_hold", 32'(frame_err), 32'd1);
      send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
      idle(4);
      expect_frame(0, "clean", 8'h81, 1'b0, 1'b0);

      // Even parity: 0x07 has three ones, so the correct parity bit is 1
      send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, -1);
      idle(4);
      expect_frame(1, "par0", 8'h07, 1'b1, 1'b0);
      send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, -1);
      idle(4);
      expect_frame(1, "par1", 8'h07, 1'b0, 1'b0);

      // One-cycle low glitch at the sample point of data bit 0 (a 1)
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 0);
      idle(4);
      expect_frame(0, "glitch", GLITCH_EXP, 1'b0, 1'b0);

      // Reset mid-DATA, then a clean frame
      send_level(0, 1'b0, SR);
      send_level(0, 1'b1, 3 * SR);
      check_eq("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mrst_data",  32'(data_out),   32'd0);
      check_eq("mrst_valid", 32'(data_valid), 32'd0);
      check_eq("mrst_perr",  32'(parity_err), 32'd0);
      check_eq("mrst_ferr",  32'(frame_err),  32'd0);
      check_eq("mrst_busy",  32'(busy),       32'd0);
      check_eq("mrst_ss",    32'(sample_sig), 32'd0);
      din = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(4);
      vq.delete();
      send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, -1);
      idle(4);
      expect_frame(0, "after_rst", 8'h5A, 1'b0, 1'b0);

      // Back-to-back frames with no idle gap
      send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, -1);
      send_frame(0, 8'h34, 1'b0, 1'b0, 1'b1, -1);
      idle(4);
      check_eq("b2b_cnt", 32'(vq.size()), 32'd2);
      if (vq.size() == 2) begin
         check_eq("b2b_first",  32'(vq[0]), 32'h012);
         check_eq("b2b_second", 32'(vq[1]), 32'h034);
      end
      vq.delete();

      check_eq("no_consec_valid", 32'(consec), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
